// File: rtl/jbr_seq_ctrl.sv
// Multi-cycle sequencer for the bmn/brz/bz/jmor/jalm/jspal branch group.
// Fetches memory-indirect targets, pushes jspal return addresses, then issues one PC write.
module jbr_seq_ctrl #(
  parameter logic [4:0] LINK_REG = 5'd31,
  parameter logic [4:0] SP_REG   = 5'd29
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] pc4,
  input  logic [31:0] reg_s,
  input  logic [25:0] j_diraddr,
  input  logic        n,
  input  logic        z,
  input  logic [31:0] sp,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        pc_we,
  output logic [31:0] pc_next,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RD, WR, UPD} state_t;
  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_BMN   = 3'b001,
    OP_BRZ   = 3'b010,
    OP_BZ    = 3'b011,
    OP_JMOR  = 3'b100,
    OP_JALM  = 3'b101,
    OP_JSPAL = 3'b110,
    OP_RSVD  = 3'b111
  } op_t;

  state_t state, state_nx;
  op_t    op_in, op_q;
  logic [31:0] pc4_q, reg_s_q, sp_q, target_q, sp_dec;
  logic [25:0] jdir_q;
  logic        n_q, z_q;
  logic        op_valid, accept;

  assign op_in    = op_t'(op);
  assign op_valid = (op_in != OP_NONE) && (op_in != OP_RSVD);
  assign accept   = (state == IDLE) && start && op_valid;
  assign sp_dec   = sp_q - 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operands are captured once at acceptance so later input changes cannot leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_NONE;
      pc4_q    <= '0;
      reg_s_q  <= '0;
      sp_q     <= '0;
      jdir_q   <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      target_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        pc4_q   <= pc4;
        reg_s_q <= reg_s;
        sp_q    <= sp;
        jdir_q  <= j_diraddr;
        n_q     <= n;
        z_q     <= z;
      end
      if (state == RD && mem_ack) target_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pc_we     = 1'b0;
    pc_next   = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if ((op_in == OP_BMN && !n) || op_in == OP_BRZ || op_in == OP_BZ)
            state_nx = UPD;
          else
            state_nx = RD;
        end
      end
      RD: begin
        mem_req  = 1'b1;
        mem_addr = reg_s_q;
        if (mem_ack) state_nx = (op_q == OP_JSPAL) ? WR : UPD;
      end
      WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_dec;
        mem_wdata = pc4_q;
        if (mem_ack) state_nx = UPD;
      end
      UPD: begin
        pc_we    = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
        case (op_q)
          OP_BMN:   pc_next = n_q ? target_q : pc4_q;
          OP_BRZ:   pc_next = z_q ? reg_s_q : pc4_q;
          OP_BZ:    pc_next = z_q ? {pc4_q[31:28], jdir_q, 2'b00} : pc4_q;
          OP_JMOR:  pc_next = target_q;
          OP_JALM: begin
            pc_next  = target_q;
            rf_we    = 1'b1;
            rf_waddr = LINK_REG;
            rf_wdata = pc4_q;
          end
          OP_JSPAL: begin
            pc_next  = target_q;
            rf_we    = 1'b1;
            rf_waddr = SP_REG;
            rf_wdata = sp_dec;
          end
          default:  pc_next = '0;
        endcase
      end
      default: state_nx = IDLE;
    endcase
  end

  assign stall = (state != IDLE) | accept;

endmodule

// File: tb/tb_jbr_seq_ctrl.sv
// Randomized self-checking bench for jbr_seq_ctrl against a per-instruction behavioural model.
module tb_jbr_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] pc4, reg_s, sp, mem_rdata;
  logic [25:0] j_diraddr;
  logic        n, z, mem_ack;
  logic        mem_req, mem_we, stall, pc_we, rf_we, done;
  logic [31:0] mem_addr, mem_wdata, pc_next, rf_wdata;
  logic [4:0]  rf_waddr;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  jbr_seq_ctrl #(.LINK_REG(5'd31), .SP_REG(5'd29)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .pc4(pc4), .reg_s(reg_s),
    .j_diraddr(j_diraddr), .n(n), .z(z), .sp(sp),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .pc_we(pc_we),
    .pc_next(pc_next), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic garble();
    op        = 3'($urandom);
    pc4       = $urandom;
    reg_s     = $urandom;
    sp        = $urandom;
    j_diraddr = 26'($urandom);
    n         = 1'($urandom);
    z         = 1'($urandom);
    mem_rdata = $urandom;
  endtask

  // One instruction: start cycle, optional read/write phases with given wait counts, update, one idle cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] p4, input logic [31:0] rs,
                        input logic [25:0] jd, input logic nn, input logic zz,
                        input logic [31:0] s, input logic [31:0] rdat,
                        input int unsigned rdly, input int unsigned wdly);
    logic        need_rd, need_wr, exp_rfwe;
    logic [31:0] exp_pc, exp_wdata, push_addr;
    logic [4:0]  exp_waddr;
    push_addr = s - 32'd4;
    need_rd   = (o == 3'd4) || (o == 3'd5) || (o == 3'd6) || (o == 3'd1 && nn);
    need_wr   = (o == 3'd6);
    case (o)
      3'd1:    exp_pc = nn ? rdat : p4;
      3'd2:    exp_pc = zz ? rs : p4;
      3'd3:    exp_pc = zz ? {p4[31:28], jd, 2'b00} : p4;
      default: exp_pc = rdat;
    endcase
    exp_rfwe  = (o == 3'd5) || (o == 3'd6);
    exp_waddr = (o == 3'd5) ? 5'd31 : (o == 3'd6) ? 5'd29 : 5'd0;
    exp_wdata = (o == 3'd5) ? p4 : (o == 3'd6) ? push_addr : 32'd0;

    @(negedge clk);
    start = 1'b1; op = o; pc4 = p4; reg_s = rs; j_diraddr = jd; n = nn; z = zz; sp = s;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    #1;
    check("start_stall", 32'(stall), 32'd1);
    check("start_pc_we", 32'(pc_we), 32'd0);
    check("start_req", 32'(mem_req), 32'd0);

    if (need_rd) begin
      for (int unsigned i = 0; i <= rdly; i++) begin
        @(negedge clk);
        garble();
        start = 1'($urandom);
        mem_ack = (i == rdly);
        if (i == rdly) mem_rdata = rdat;
        #1;
        check("rd_req", 32'(mem_req), 32'd1);
        check("rd_we", 32'(mem_we), 32'd0);
        check("rd_addr", mem_addr, rs);
        check("rd_wdata", mem_wdata, 32'd0);
        check("rd_stall", 32'(stall), 32'd1);
        check("rd_pc_we", 32'(pc_we), 32'd0);
      end
    end

    if (need_wr) begin
      for (int unsigned i = 0; i <= wdly; i++) begin
        @(negedge clk);
        garble();
        start = 1'($urandom);
        mem_ack = (i == wdly);
        #1;
        check("wr_req", 32'(mem_req), 32'd1);
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_addr", mem_addr, push_addr);
        check("wr_wdata", mem_wdata, p4);
        check("wr_stall", 32'(stall), 32'd1);
        check("wr_pc_we", 32'(pc_we), 32'd0);
      end
    end

    @(negedge clk);
    garble();
    start = 1'($urandom);
    mem_ack = 1'($urandom);
    #1;
    check("upd_pc_we", 32'(pc_we), 32'd1);
    check("upd_done", 32'(done), 32'd1);
    check("upd_pc_next", pc_next, exp_pc);
    check("upd_rf_we", 32'(rf_we), 32'(exp_rfwe));
    check("upd_rf_waddr", 32'(rf_waddr), 32'(exp_waddr));
    check("upd_rf_wdata", rf_wdata, exp_wdata);
    check("upd_req", 32'(mem_req), 32'd0);
    check("upd_stall", 32'(stall), 32'd1);

    @(negedge clk);
    garble();
    start = 1'b0;
    mem_ack = 1'($urandom);
    #1;
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_pc_we", 32'(pc_we), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_rf_we", 32'(rf_we), 32'd0);
    check("idle_req", 32'(mem_req), 32'd0);
  endtask

  task automatic invalid_op(input logic [2:0] o);
    @(negedge clk);
    garble();
    start = 1'b1; op = o; mem_ack = 1'b0;
    #1;
    check("inv_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("inv_pc_we", 32'(pc_we), 32'd0);
    check("inv_stall_after", 32'(stall), 32'd0);
    check("inv_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
    garble();
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_pc_we", 32'(pc_we), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_pc_next", pc_next, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(3'd2, 32'h0000_0104, 32'h0000_0400, 26'h0, 1'b0, 1'b1, 32'h0, 32'h0, 0, 0);
    run_op(3'd3, 32'h1000_0008, 32'h0, 26'h0000010, 1'b0, 1'b1, 32'h0, 32'h0, 0, 0);
    run_op(3'd3, 32'h1000_0008, 32'h0, 26'h0000010, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
    run_op(3'd5, 32'h0000_0024, 32'h0000_0200, 26'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3000, 3, 0);
    run_op(3'd6, 32'h0000_0044, 32'h0000_0300, 26'h0, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_0500, 0, 0);
    run_op(3'd6, 32'h0000_0048, 32'h0000_0300, 26'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0600, 1, 2);
    run_op(3'd1, 32'h0000_0080, 32'h0000_0900, 26'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
    run_op(3'd1, 32'h0000_0080, 32'h0000_0900, 26'h0, 1'b1, 1'b0, 32'h0, 32'h0000_7770, 2, 0);
    invalid_op(3'b111);
    invalid_op(3'b000);

    // Reset while a read is outstanding.
    @(negedge clk);
    start = 1'b1; op = 3'd5; pc4 = 32'h60; reg_s = 32'h200; sp = 32'h1000; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_pc_we", 32'(pc_we), 32'd0);
    check("mid_rst_rf_we", 32'(rf_we), 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = 1'($urandom);
      #1;
      check("post_rst_pc_we", 32'(pc_we), 32'd0);
      check("post_rst_rf_we", 32'(rf_we), 32'd0);
      check("post_rst_req", 32'(mem_req), 32'd0);
    end
    run_op(3'd2, 32'h0000_0204, 32'h0000_0abc, 26'h0, 1'b0, 1'b1, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) invalid_op($urandom_range(0, 1) == 0 ? 3'b000 : 3'b111);
      run_op(3'($urandom_range(1, 6)), $urandom, $urandom, 26'($urandom),
             1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jbr_seq_ctrl.md
# jbr_seq_ctrl

Multi-cycle sequencer for the branch/jump instruction group: bmn, brz, bz, jmor, jalm, jspal. It sits between the instruction decoder and the PC/register-file write ports. It stalls the core while a memory-indirect target is fetched from data memory over a req/ack handshake. For jspal it also pushes the return address to the stack. When the sequence finishes it issues exactly one PC write, plus the required link or stack-pointer register write.

## Interface
Parameters:
- LINK_REG, 5'd31: register written with pc4 by jalm
- SP_REG, 5'd29: stack-pointer register updated by jspal

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- start  input  1  decoder strobe: current instruction belongs to the group
- op  input  3  {status2,status1,status0}: 001 bmn, 010 brz, 011 bz, 100 jmor, 101 jalm, 110 jspal; 000/111 invalid
- pc4  input  32  PC+4 of the current instruction
- reg_s  input  32  Rs value: target for brz, memory address for bmn/jmor/jalm/jspal
- j_diraddr  input  26  direct target field for bz
- n, z  input  1  status flags
- sp  input  32  current value of SP_REG
- mem_req  output  1  data-memory request
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  32  request address
- mem_wdata  output  32  write data
- mem_ack  input  1  request accepted; read data is valid in the same cycle
- mem_rdata  input  32  read data
- stall  output  1  freeze fetch/decode
- pc_we  output  1  PC load strobe
- pc_next  output  32  value to load into PC
- rf_we  output  1  register-file write strobe
- rf_waddr  output  5  register-file write address
- rf_wdata  output  32  register-file write data
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, RD, WR, UPD.
- IDLE, start=1, valid op: latch op, pc4, reg_s, j_diraddr, n, z and sp. Then:
  - brz, bz, or bmn with n=0: go to UPD.
  - bmn with n=1, jmor, jalm, jspal: go to RD.
- IDLE, start=1, invalid op: ignored. No stall, stay IDLE.
- start is ignored in every state other than IDLE.
- RD: mem_req=1, mem_we=0, mem_addr=latched reg_s. On mem_ack, capture mem_rdata as the target. Next state is WR for jspal, UPD for all others.
- WR (jspal only): mem_req=1, mem_we=1, mem_addr=sp-4, mem_wdata=pc4. On mem_ack, go to UPD.
- UPD: pc_we=1, done=1, return to IDLE. pc_next per op:
  - bmn: n ? target : pc4
  - brz: z ? reg_s : pc4
  - bz: z ? {pc4[31:28], j_diraddr, 2'b00} : pc4
  - jmor, jalm, jspal: target
- UPD register writes:
  - jalm: rf_we=1, rf_waddr=LINK_REG, rf_wdata=pc4.
  - jspal: rf_we=1, rf_waddr=SP_REG, rf_wdata=sp-4.
  - All other ops: rf_we=0.
- Arithmetic: sp-4 is 32-bit modulo. sp=0 yields 32'hFFFFFFFC with no flag.
- Inactive outputs are driven to 0.

## Timing
- Reset values: state IDLE. stall, pc_we, rf_we, mem_req, mem_we and done are 0. pc_next, mem_addr, mem_wdata, rf_waddr and rf_wdata are 0.
- stall = (state != IDLE) | (start & valid op & state == IDLE). It is combinational, so it is high in the start cycle T. It is high through the UPD cycle and low the cycle after.
- Latency with start at cycle T:
  - Non-memory op: UPD at T+1.
  - Read op: RD from T+1. If ack arrives at cycle A, UPD is at A+1.
  - jspal: WR at A+1. If the write ack arrives at B, UPD is at B+1.
- Zero-wait memory (ack in the first request cycle):
  - bmn/jmor/jalm: UPD at T+2.
  - jspal: UPD at T+3.
- Handshake: mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled high. mem_req drops in the cycle after the ack. mem_ack while mem_req=0 is ignored.
- pc_we, done and rf_we are each high for exactly one cycle per accepted instruction.
- Input changes after cycle T have no effect, because all operands are latched.
- Reset asserted mid-sequence: outputs clear immediately (asynchronous). No pc_we or rf_we is issued. A pending request is abandoned, and the memory side must tolerate a dropped request.

## Test plan
- brz, z=1, reg_s=32'h0000_0400, start at T -> pc_we at T+1 with pc_next=32'h400; stall high at T and T+1 only; rf_we=0.
- bz, z=1, pc4=32'h1000_0008, j_diraddr=26'h0000010 -> pc_next=32'h1000_0040 at T+1. Repeat with z=0 -> pc_next=32'h1000_0008.
- jalm, reg_s=32'h200, ack delayed 3 cycles, mem_rdata=32'h0000_3000:
  - mem_req held with mem_addr=32'h200 for 3 cycles.
  - UPD follows: pc_next=32'h3000, rf_waddr=31, rf_wdata=pc4.
- jspal, sp=32'h0000_1000, pc4=32'h44, zero-wait memory, rdata=32'h500:
  - Read at T+1, then write at T+2 with addr=32'hFFC, wdata=32'h44.
  - UPD at T+3: pc_next=32'h500, rf_waddr=29, rf_wdata=32'hFFC.
- bmn with n=0 -> no mem_req, pc_next=pc4 at T+1. Invalid op 3'b111 with start=1 -> stall=0, no pc_we.
- Reset asserted during RD wait -> mem_req and stall drop asynchronously, no pc_we/rf_we. A fresh brz after reset release completes normally. start pulses during busy states are ignored.
